// File: rtl/module_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : module_instruction_fetch
// Purpose  : MIPS instruction fetch stage. Holds the PC, addresses an
//            instruction memory with a one-cycle registered read, and hands
//            each fetched word to decode with its PC and a valid flag.
//            Supports decode back-pressure (stall) and branch/jump redirects.
// Revision : 1.0 - initial release
// ============================================================================
module module_instruction_fetch #(
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned MEMORY       = 1024,
    parameter int unsigned RESET_PC     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [ADDRESS_BITS-1:0] redirect_target,
    input  logic [WORD_SIZE-1:0]    instruction,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    output logic [WORD_SIZE-1:0]    if_instr,
    output logic [ADDRESS_BITS-1:0] if_pc,
    output logic                    if_valid,
    output logic                    addr_err
);

    localparam logic [ADDRESS_BITS-1:0] c_RESET_PC = ADDRESS_BITS'(RESET_PC);
    localparam logic [ADDRESS_BITS-1:0] c_LAST_PC  = ADDRESS_BITS'(MEMORY - 1);
    localparam logic [ADDRESS_BITS-1:0] c_ONE      = ADDRESS_BITS'(1);
    // One extra bit so a memory depth of exactly 2^ADDRESS_BITS still compares correctly
    localparam logic [ADDRESS_BITS:0]   c_MEM_DEPTH = (ADDRESS_BITS + 1)'(MEMORY);

    // Fetch pointer, in-flight request and decode-facing output registers
    logic [ADDRESS_BITS-1:0] r_pc_q,       w_pc_d;
    logic [ADDRESS_BITS-1:0] r_pend_pc_q,  w_pend_pc_d;
    logic                    r_pend_valid_q, w_pend_valid_d;
    logic [WORD_SIZE-1:0]    r_if_instr_q, w_if_instr_d;
    logic [ADDRESS_BITS-1:0] r_if_pc_q,    w_if_pc_d;
    logic                    r_if_valid_q, w_if_valid_d;
    logic                    r_addr_err_q, w_addr_err_d;

    logic                    w_target_ok;

    assign w_target_ok = ({1'b0, redirect_target} < c_MEM_DEPTH);

    // During a stall the in-flight address is re-presented so the memory keeps
    // returning the same word, which removes the need for a skid buffer.
    assign imem_addr = stall ? r_pend_pc_q : r_pc_q;

    // Next-state selection with priority redirect > stall > advance
    always_comb begin
        w_pc_d         = r_pc_q;
        w_pend_pc_d    = r_pend_pc_q;
        w_pend_valid_d = r_pend_valid_q;
        w_if_instr_d   = r_if_instr_q;
        w_if_pc_d      = r_if_pc_q;
        w_if_valid_d   = r_if_valid_q;
        w_addr_err_d   = 1'b0;

        if (redirect) begin
            // Flush both the outstanding request and the word held for decode
            w_pend_valid_d = 1'b0;
            w_if_valid_d   = 1'b0;
            if (w_target_ok) begin
                w_pc_d = redirect_target;
            end else begin
                w_pc_d       = '0;
                w_addr_err_d = 1'b1;
            end
        end else if (!stall) begin
            w_pend_pc_d    = r_pc_q;
            w_pend_valid_d = 1'b1;
            w_pc_d         = (r_pc_q == c_LAST_PC) ? '0 : (r_pc_q + c_ONE);
            w_if_instr_d   = instruction;
            w_if_pc_d      = r_pend_pc_q;
            w_if_valid_d   = r_pend_valid_q;
        end
    end

    // State update with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q         <= c_RESET_PC;
            r_pend_pc_q    <= '0;
            r_pend_valid_q <= 1'b0;
            r_if_instr_q   <= '0;
            r_if_pc_q      <= '0;
            r_if_valid_q   <= 1'b0;
            r_addr_err_q   <= 1'b0;
        end else begin
            r_pc_q         <= w_pc_d;
            r_pend_pc_q    <= w_pend_pc_d;
            r_pend_valid_q <= w_pend_valid_d;
            r_if_instr_q   <= w_if_instr_d;
            r_if_pc_q      <= w_if_pc_d;
            r_if_valid_q   <= w_if_valid_d;
            r_addr_err_q   <= w_addr_err_d;
        end
    end

    assign if_instr = r_if_instr_q;
    assign if_pc    = r_if_pc_q;
    assign if_valid = r_if_valid_q;
    assign addr_err = r_addr_err_q;

endmodule
`default_nettype wire
